// File: rtl/vector_lane_sequencer.sv
// Issue/writeback sequencer for one vector PE lane: for each packed word it reads
// the operands, runs the PE until pe_done, and writes the result back.
module vector_lane_sequencer #(
    parameter int VREG_W  = 5,
    parameter int IDX_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [7:0]                cmd_op,
    input  logic [VREG_W-1:0]         cmd_vd,
    input  logic [VREG_W-1:0]         cmd_vs1,
    input  logic [VREG_W-1:0]         cmd_vs2,
    input  logic [IDX_W:0]            cmd_nwords,
    input  logic [9:0]                cmd_sew,
    input  logic [3:0]                cmd_vap,
    output logic                      busy,
    output logic                      cmd_done,
    output logic                      cmd_err,
    output logic [VREG_W+IDX_W-1:0]   rf_raddr_a,
    output logic [VREG_W+IDX_W-1:0]   rf_raddr_b,
    output logic [VREG_W+IDX_W-1:0]   rf_raddr_c,
    input  logic [31:0]               rf_rdata_a,
    input  logic [31:0]               rf_rdata_b,
    input  logic [31:0]               rf_rdata_c,
    output logic                      rf_we,
    output logic [VREG_W+IDX_W-1:0]   rf_waddr,
    output logic [31:0]               rf_wdata,
    output logic [7:0]                pe_instruction,
    output logic [9:0]                pe_sew,
    output logic [3:0]                pe_vap,
    output logic                      pe_start,
    output logic [31:0]               pe_opA,
    output logic [31:0]               pe_opB,
    output logic [31:0]               pe_opC,
    input  logic                      pe_done,
    input  logic [31:0]               pe_out,
    output logic [2:0]                state_dbg
);

    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_RUN   = 3'd3,
        S_WB    = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t              state;
    logic [VREG_W-1:0]   vd_q;
    logic [VREG_W-1:0]   vs1_q;
    logic [VREG_W-1:0]   vs2_q;
    logic [IDX_W-1:0]    idx;
    logic [IDX_W-1:0]    last_idx;
    logic [TW-1:0]       tcnt;
    logic [IDX_W:0]      nwords_m1;
    logic [IDX_W-1:0]    idx_nxt;

    // Handshake: a command transfers on a clock edge where cmd_valid && cmd_ready.
    // cmd_ready is high only in IDLE, so cmd_valid while busy is simply not taken.
    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    // nwords == 2^IDX_W gives last_idx = all-ones, so idx never has to wrap.
    assign nwords_m1 = cmd_nwords - (IDX_W + 1)'(1);
    assign idx_nxt   = idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            vd_q           <= '0;
            vs1_q          <= '0;
            vs2_q          <= '0;
            idx            <= '0;
            last_idx       <= '0;
            tcnt           <= '0;
            cmd_done       <= 1'b0;
            cmd_err        <= 1'b0;
            rf_raddr_a     <= '0;
            rf_raddr_b     <= '0;
            rf_raddr_c     <= '0;
            rf_we          <= 1'b0;
            rf_waddr       <= '0;
            rf_wdata       <= '0;
            pe_instruction <= '0;
            pe_sew         <= '0;
            pe_vap         <= '0;
            pe_start       <= 1'b0;
            pe_opA         <= '0;
            pe_opB         <= '0;
            pe_opC         <= '0;
        end else begin
            cmd_done <= 1'b0;
            rf_we    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        pe_instruction <= cmd_op;
                        pe_sew         <= cmd_sew;
                        pe_vap         <= cmd_vap;
                        vd_q           <= cmd_vd;
                        vs1_q          <= cmd_vs1;
                        vs2_q          <= cmd_vs2;
                        last_idx       <= nwords_m1[IDX_W-1:0];
                        idx            <= '0;
                        if (cmd_op > 8'h07) begin
                            cmd_err  <= 1'b1;
                            cmd_done <= 1'b1;
                            state    <= S_DONE;
                        end else if (cmd_nwords == '0) begin
                            cmd_err  <= 1'b0;
                            cmd_done <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            rf_raddr_a <= {cmd_vs1, {IDX_W{1'b0}}};
                            rf_raddr_b <= {cmd_vs2, {IDX_W{1'b0}}};
                            rf_raddr_c <= {cmd_vd, {IDX_W{1'b0}}};
                            state      <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    // Read data is valid now, one cycle after the address.
                    pe_opA   <= rf_rdata_a;
                    pe_opB   <= rf_rdata_b;
                    pe_opC   <= rf_rdata_c;
                    tcnt     <= '0;
                    pe_start <= 1'b1;
                    state    <= S_RUN;
                end
                S_RUN: begin
                    if (pe_done) begin
                        rf_wdata <= pe_out;
                        rf_waddr <= {vd_q, idx};
                        rf_we    <= 1'b1;
                        pe_start <= 1'b0;
                        state    <= S_WB;
                    end else if (tcnt == TW'(TIMEOUT - 1)) begin
                        pe_start <= 1'b0;
                        cmd_err  <= 1'b1;
                        cmd_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                S_WB: begin
                    if (idx == last_idx) begin
                        cmd_err  <= 1'b0;
                        cmd_done <= 1'b1;
                        state    <= S_DONE;
                    end else begin
                        idx        <= idx_nxt;
                        rf_raddr_a <= {vs1_q, idx_nxt};
                        rf_raddr_b <= {vs2_q, idx_nxt};
                        rf_raddr_c <= {vd_q, idx_nxt};
                        state      <= S_READ;
                    end
                end
                S_DONE: begin
                    cmd_err <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Bench for vector_lane_sequencer: RF and PE behavioural models, scoreboard of
// expected writebacks, directed cases plus randomized commands.
module tb_vector_lane_sequencer;

    localparam int VREG_W  = 5;
    localparam int IDX_W   = 5;
    localparam int TIMEOUT = 64;
    localparam int AW      = VREG_W + IDX_W;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [7:0]        cmd_op = '0;
    logic [VREG_W-1:0] cmd_vd = '0, cmd_vs1 = '0, cmd_vs2 = '0;
    logic [IDX_W:0]    cmd_nwords = '0;
    logic [9:0]        cmd_sew = '0;
    logic [3:0]        cmd_vap = '0;
    logic              busy, cmd_done, cmd_err;
    logic [AW-1:0]     rf_raddr_a, rf_raddr_b, rf_raddr_c, rf_waddr;
    logic [31:0]       rf_rdata_a = '0, rf_rdata_b = '0, rf_rdata_c = '0;
    logic              rf_we;
    logic [31:0]       rf_wdata;
    logic [7:0]        pe_instruction;
    logic [9:0]        pe_sew;
    logic [3:0]        pe_vap;
    logic              pe_start;
    logic [31:0]       pe_opA, pe_opB, pe_opC;
    logic              pe_done = 1'b0;
    logic [31:0]       pe_out = '0;
    logic [2:0]        state_dbg;

    vector_lane_sequencer #(.VREG_W(VREG_W), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_vd(cmd_vd), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2),
        .cmd_nwords(cmd_nwords), .cmd_sew(cmd_sew), .cmd_vap(cmd_vap),
        .busy(busy), .cmd_done(cmd_done), .cmd_err(cmd_err),
        .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_raddr_c(rf_raddr_c),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_rdata_c(rf_rdata_c),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pe_instruction(pe_instruction), .pe_sew(pe_sew), .pe_vap(pe_vap),
        .pe_start(pe_start), .pe_opA(pe_opA), .pe_opB(pe_opB), .pe_opC(pe_opC),
        .pe_done(pe_done), .pe_out(pe_out), .state_dbg(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    logic [31:0]        mem [0:(1<<AW)-1];
    logic [AW+31:0]     exp_q[$];
    logic [AW+31:0]     e;
    int                 checks = 0;
    int                 errors = 0;
    int                 pe_cnt = 0, run_len = 0, exp_r = 0;
    int                 wr_count = 0, done_count = 0;
    bit                 pe_hang = 1'b0;
    logic [7:0]         cur_op = '0;
    logic [9:0]         cur_sew = '0;
    logic [3:0]         cur_vap = '0;
    logic [AW-1:0]      ra_a = '0, ra_b = '0, ra_c = '0;
    logic [117:0]       snap = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // PE opcode map used by the model: 0 vadd, 1 vsub, 2 vmul, 3 vdot, 4 vdotvarp,
    // 5 and, 6 or, 7 xor; all lane-wise at the given SEW.
    function automatic logic [31:0] pe_fn(input logic [7:0] op, input logic [9:0] sew,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c);
        int w;
        logic [63:0] m, x, y, z, r;
        logic [31:0] res;
        w = (sew == 10'd8) ? 8 : (sew == 10'd16) ? 16 : 32;
        m = (64'd1 << w) - 64'd1;
        res = '0;
        for (int l = 0; l < 32 / w; l++) begin
            x = 64'(a >> (l * w)) & m;
            y = 64'(b >> (l * w)) & m;
            z = 64'(c >> (l * w)) & m;
            case (op)
                8'd0:       r = x + y;
                8'd1:       r = x - y;
                8'd2:       r = x * y;
                8'd3, 8'd4: r = x * y + z;
                8'd5:       r = x & y;
                8'd6:       r = x | y;
                default:    r = x ^ y;
            endcase
            res = res | 32'((r & m) << (l * w));
        end
        return res;
    endfunction

    function automatic int lat(input logic [7:0] op, input logic [9:0] sew);
        return (op == 8'd2 || op == 8'd3 || op == 8'd4) ? int'(sew) + 2 : 2;
    endfunction

    // ---------------- RF model: synchronous read ----------------
    always @(posedge clk) begin
        #1;
        rf_rdata_a = mem[ra_a];
        rf_rdata_b = mem[ra_b];
        rf_rdata_c = mem[ra_c];
    end

    // ---------------- monitor + PE model ----------------
    always @(negedge clk) begin
        ra_a = rf_raddr_a;
        ra_b = rf_raddr_b;
        ra_c = rf_raddr_c;
        if (!reset) begin
            pe_cnt  = 0;
            run_len = 0;
            pe_done = 1'b0;
        end else begin
            if (rf_we) begin
                wr_count++;
                check("wb_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("wb_addr_data", {rf_waddr, rf_wdata}, e);
                end
                check("wb_pe_start_low", pe_start, 0);
                check("wb_run_len", run_len, exp_r);
                mem[rf_waddr] = rf_wdata;
            end
            if (cmd_done) done_count++;
            if (pe_start) begin
                if (pe_cnt == 0) begin
                    snap = {pe_opA, pe_opB, pe_opC, pe_instruction, pe_sew, pe_vap};
                    check("pe_ctrl", {pe_instruction, pe_sew, pe_vap}, {cur_op, cur_sew, cur_vap});
                end else begin
                    check("pe_hold", {pe_opA, pe_opB, pe_opC, pe_instruction, pe_sew, pe_vap}, snap);
                end
                pe_cnt++;
                run_len = pe_cnt;
                if (!pe_hang && pe_cnt == lat(pe_instruction, pe_sew)) begin
                    pe_done = 1'b1;
                    pe_out  = pe_fn(pe_instruction, pe_sew, pe_opA, pe_opB, pe_opC);
                end else begin
                    pe_done = 1'b0;
                    pe_out  = $urandom;
                end
            end else begin
                // Stray pe_done outside RUN must be ignored by the sequencer.
                pe_cnt  = 0;
                pe_done = ($urandom_range(0, 3) == 0);
                pe_out  = $urandom;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic setup_exp(input logic [7:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                             input logic [4:0] vs2, input logic [5:0] n, input logic [9:0] sew,
                             input logic [3:0] vap, input bit hang,
                             output bit exp_err, output int exp_cyc);
        logic [IDX_W-1:0] ii;
        exp_err = (op > 8'd7) || (hang && n != 0);
        if (op > 8'd7 || n == 0) exp_cyc = 1;
        else if (hang)           exp_cyc = 3 + TIMEOUT;
        else                     exp_cyc = int'(n) * (3 + lat(op, sew)) + 1;
        exp_q.delete();
        if (!exp_err) begin
            for (int i = 0; i < int'(n); i++) begin
                ii = IDX_W'(i);
                exp_q.push_back({vd, ii, pe_fn(op, sew, mem[{vs1, ii}], mem[{vs2, ii}], mem[{vd, ii}])});
            end
        end
        cur_op  = op;
        cur_sew = sew;
        cur_vap = vap;
        exp_r   = lat(op, sew);
        pe_hang = hang;
    endtask

    task automatic issue_cmd(input string tag, input logic [7:0] op, input logic [4:0] vd,
                             input logic [4:0] vs1, input logic [4:0] vs2, input logic [5:0] n,
                             input logic [9:0] sew, input logic [3:0] vap);
        @(posedge clk); #1;
        cmd_op = op; cmd_vd = vd; cmd_vs1 = vs1; cmd_vs2 = vs2;
        cmd_nwords = n; cmd_sew = sew; cmd_vap = vap;
        cmd_valid = 1'b1;
        @(negedge clk);
        check({tag, "_ready"}, cmd_ready, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_op = 8'($urandom); cmd_vd = 5'($urandom); cmd_nwords = 6'($urandom);
    endtask

    task automatic run_cmd(input string tag, input logic [7:0] op, input logic [4:0] vd,
                           input logic [4:0] vs1, input logic [4:0] vs2, input logic [5:0] n,
                           input logic [9:0] sew, input logic [3:0] vap, input bit hang);
        bit exp_err, seen;
        int exp_cyc, cyc;
        setup_exp(op, vd, vs1, vs2, n, sew, vap, hang, exp_err, exp_cyc);
        issue_cmd(tag, op, vd, vs1, vs2, n, sew, vap);
        cyc = 0;
        seen = 1'b0;
        while (!seen && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (cmd_done) seen = 1'b1;
            // A command offered while busy must not be taken.
            if (cyc == 3 && exp_cyc > 6) begin
                cmd_op = 8'd0; cmd_nwords = 6'd1; cmd_valid = 1'b1;
            end
            if (cyc == 4) cmd_valid = 1'b0;
        end
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_err"}, cmd_err, exp_err);
        @(negedge clk);
        check({tag, "_after"}, {cmd_ready, cmd_done, busy}, 3'b100);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
        exp_q.delete();
        pe_hang = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int w0, d0, guard;
        bit found;
        logic [31:0] old1;
        logic [7:0] rop;
        logic [5:0] rn;
        logic [9:0] rsew;

        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;

        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {busy, cmd_done, cmd_err, rf_we, pe_start, cmd_ready, state_dbg}, 9'b000001000);
        check("rst_addr", {rf_raddr_a, rf_raddr_b, rf_raddr_c, rf_waddr, rf_wdata}, 0);
        check("rst_pe", {pe_instruction, pe_sew, pe_vap, pe_opA, pe_opB, pe_opC}, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // vadd SEW=8, two words
        mem[{5'd1, 5'd0}] = 32'h01020304; mem[{5'd1, 5'd1}] = 32'h7F000001;
        mem[{5'd2, 5'd0}] = 32'h10203040; mem[{5'd2, 5'd1}] = 32'h01000001;
        d0 = done_count;
        run_cmd("vadd8", 8'd0, 5'd3, 5'd1, 5'd2, 6'd2, 10'd8, 4'd0, 1'b0);
        check("vadd8_w0", mem[{5'd3, 5'd0}], 32'h11223344);
        check("vadd8_w1", mem[{5'd3, 5'd1}], 32'h80000002);
        check("vadd8_one_done", done_count - d0, 1);

        // vmul SEW=32, 34 RUN cycles
        mem[{5'd4, 5'd0}] = 32'd3; mem[{5'd5, 5'd0}] = 32'hFFFFFFFE;
        run_cmd("vmul32", 8'd2, 5'd6, 5'd4, 5'd5, 6'd1, 10'd32, 4'd5, 1'b0);
        check("vmul32_w0", mem[{5'd6, 5'd0}], 32'hFFFFFFFA);

        // vdot SEW=16 accumulating into vd
        mem[{5'd7, 5'd0}] = 32'h00020003; mem[{5'd8, 5'd0}] = 32'h00040005;
        mem[{5'd9, 5'd0}] = 32'h00010001;
        run_cmd("vdot16", 8'd3, 5'd9, 5'd7, 5'd8, 6'd1, 10'd16, 4'd3, 1'b0);
        check("vdot16_w0", mem[{5'd9, 5'd0}], 32'h00090010);

        // zero-length and illegal opcode: no RF writes
        w0 = wr_count;
        run_cmd("nwords0", 8'd0, 5'd10, 5'd1, 5'd2, 6'd0, 10'd8, 4'd0, 1'b0);
        run_cmd("illegal_op", 8'h09, 5'd10, 5'd1, 5'd2, 6'd5, 10'd8, 4'd0, 1'b0);
        run_cmd("timeout", 8'd0, 5'd11, 5'd1, 5'd2, 6'd2, 10'd32, 4'd0, 1'b1);
        check("no_write_err_cmds", wr_count - w0, 0);

        // full-length vector ends at idx all-ones
        run_cmd("nwords_max", 8'd1, 5'd12, 5'd13, 5'd14, 6'd32, 10'd16, 4'd1, 1'b0);

        // randomized commands
        for (int t = 0; t < 12; t++) begin
            rop  = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
            rn   = ($urandom_range(0, 4) == 0) ? 6'd32 : 6'($urandom_range(0, 8));
            rsew = 10'(8 << $urandom_range(0, 2));
            run_cmd("rand", rop, 5'($urandom), 5'($urandom), 5'($urandom), rn, rsew,
                    4'($urandom), 1'b0);
        end

        // reset during RUN of word 1 of 3
        old1 = mem[{5'd15, 5'd1}];
        begin
            bit ee; int ec;
            setup_exp(8'd2, 5'd15, 5'd16, 5'd17, 6'd3, 10'd32, 4'd2, 1'b0, ee, ec);
        end
        w0 = wr_count;
        issue_cmd("rst_mid", 8'd2, 5'd15, 5'd16, 5'd17, 6'd3, 10'd32, 4'd2);
        found = 1'b0;
        guard = 0;
        while (!found && guard < 500) begin
            @(negedge clk);
            guard++;
            if (wr_count == w0 + 1 && pe_start && pe_cnt >= 5) found = 1'b1;
        end
        check("rst_mid_reached_word1", found, 1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_state", {busy, pe_start, rf_we, cmd_done, cmd_ready, state_dbg}, 8'b00001000);
        reset = 1'b1;
        exp_q.delete();
        w0 = wr_count;
        d0 = done_count;
        repeat (80) @(negedge clk);
        check("rst_mid_no_write", wr_count - w0, 0);
        check("rst_mid_no_done", done_count - d0, 0);
        check("rst_mid_partial", mem[{5'd15, 5'd1}], old1);

        mem[{5'd18, 5'd0}] = 32'h000000FF; mem[{5'd19, 5'd0}] = 32'h00000001;
        run_cmd("after_rst", 8'd0, 5'd20, 5'd18, 5'd19, 6'd1, 10'd32, 4'd0, 1'b0);
        check("after_rst_w0", mem[{5'd20, 5'd0}], 32'h00000100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_lane_sequencer.md
# vector_lane_sequencer

Issue/writeback sequencer that sits directly upstream of `vector_processing_element` and drives one PE lane. It accepts one vector command at a time and walks its packed 32-bit words. For each word it reads the operands from the vector register file, holds them stable while the PE runs, and waits for `pe_done`. It then writes `pe_out` back to the destination register and returns `start` low so the PE resets between words.

## Interface
Parameters:
- VREG_W, 5, vector register index width
- IDX_W, 5, word-index width; a vector holds up to 2^IDX_W words
- TIMEOUT, 64, maximum RUN cycles per word before abort

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high in IDLE only
- cmd_op  in  8  PE opcode; 0x00–0x07 legal
- cmd_vd, cmd_vs1, cmd_vs2  in  VREG_W  destination and sources
- cmd_nwords  in  IDX_W+1  number of 32-bit words, 0..2^IDX_W
- cmd_sew  in  10  8, 16 or 32
- cmd_vap  in  4  variable-precision width
- busy  out  1  state != IDLE
- cmd_done  out  1  one-cycle pulse at end of command
- cmd_err  out  1  qualified by cmd_done
- rf_raddr_a, rf_raddr_b, rf_raddr_c  out  VREG_W+IDX_W  read addresses {vs1,idx}, {vs2,idx}, {vd,idx}
- rf_rdata_a, rf_rdata_b, rf_rdata_c  in  32  synchronous read data, valid the cycle after the address
- rf_we  out  1  write enable
- rf_waddr  out  VREG_W+IDX_W  {vd,idx}
- rf_wdata  out  32  result word
- pe_instruction  out  8  latched opcode
- pe_sew  out  10  latched SEW
- pe_vap  out  4  latched vap
- pe_start  out  1  PE start
- pe_opA, pe_opB, pe_opC  out  32  operand registers
- pe_done  in  1  PE completion
- pe_out  in  32  PE result

## Operation
- States:
  - IDLE: accept command when cmd_valid && cmd_ready; latch op/vd/vs1/vs2/nwords/sew/vap; clear idx.
    - Illegal opcode (>0x07) → DONE with cmd_err=1; no RF access.
    - nwords==0 → DONE with cmd_err=0.
    - Otherwise → READ.
  - READ (1 cycle): drive rf_raddr_a/b/c for the current idx → LATCH.
  - LATCH (1 cycle): capture rf_rdata_a/b/c into pe_opA/B/C at the clock edge; clear timeout counter → RUN.
  - RUN: pe_start=1; pe_opA/B/C, pe_instruction, pe_sew and pe_vap are held constant.
    - On a cycle with pe_done=1: capture pe_out → WB.
    - Timeout counter reaches TIMEOUT-1 without pe_done: → DONE with cmd_err=1; no write for that word.
  - WB (1 cycle): pe_start=0; rf_we=1, rf_waddr={vd,idx}, rf_wdata=captured result.
    - idx==nwords-1 → DONE.
    - Else idx+1 → READ.
  - DONE (1 cycle): cmd_done=1, cmd_err as determined → IDLE.
- pe_start is low in every state except RUN. The PE therefore sees start low for at least the WB, READ and LATCH cycles (3 cycles) between words and clears itself.
- vdot/vdotvarp accumulate in place: opC is the old vd word. For all other ops opC is still read but the PE ignores it.
- Operand pass-through is raw 32-bit; the block performs no arithmetic on data.
- idx is IDX_W bits; nwords = 2^IDX_W is legal and ends at idx = all-ones, with no wrap.
- cmd_valid arriving while busy is ignored (cmd_ready=0).
- reset low at any clock edge: return to IDLE with no write and no cmd_done. A partially written vector stays partial.

## Timing
- Reset values: busy 0, cmd_done 0, cmd_err 0, rf_we 0, pe_start 0, all addresses/data/operand/pe_* registers 0, cmd_ready 1.
- All outputs are registered, except cmd_ready and busy, which decode state.
- Per-word latency is 3 + R cycles (READ + LATCH + R RUN cycles + WB), where R counts RUN cycles up to and including the one in which pe_done=1:
  - vadd/vsub: R=2, 5 cycles/word.
  - vmul SEW=32: R=34, 37 cycles/word.
- The command takes nwords×(3+R) cycles after acceptance, plus 1 DONE cycle.
- pe_done high in any state other than RUN is ignored.
- TIMEOUT must exceed the worst-case PE latency (34 RUN cycles, SEW=32 multiply).

## Test plan
- vadd SEW=8, nwords=2, vs1 words 0x01020304/0x7F000001, vs2 words 0x10203040/0x01000001 → writes 0x11223344 then 0x80000002 to {vd,0},{vd,1}; one cmd_done, cmd_err=0.
- vmul SEW=32, opA=3, opB=0xFFFFFFFE → rf_wdata 0xFFFFFFFA; RUN lasts 34 cycles; pe_start drops in WB.
- vdot SEW=16, opA=0x00020003, opB=0x00040005, old vd word 0x00010001 → 0x0009_0010.
- nwords=0 and, separately, op=0x09 → cmd_done one cycle after acceptance; cmd_err 0 and 1 respectively; rf_we never asserted.
- PE model holds pe_done low → after 64 RUN cycles: cmd_done=1, cmd_err=1, no write, cmd_ready high the next cycle.
- reset low during RUN of word 1 of 3 → next cycle: IDLE, pe_start=0, no further rf_we, no cmd_done; a new command then runs correctly.
